// File: rtl/sha_pad_ctrl.sv
// Packs a UART byte stream into 512-bit SHA message blocks. The controller appends
// the 0x80 marker, zero fill and the 64-bit big-endian bit length, then sequences the core.
module sha_pad_ctrl #(
    parameter int END_ON_CR = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        msg_end,
    output logic [31:0] blk_word,
    output logic [3:0]  blk_idx,
    output logic        blk_we,
    output logic        sha_start,
    output logic        sha_first,
    input  logic        sha_done,
    output logic        busy,
    output logic        msg_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_PAD80, S_PADZ, S_LENHI, S_LENLO, S_START, S_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [6:0]  r_pos;
    logic [31:0] r_byte_cnt;
    logic [31:0] r_acc;
    logic [31:0] r_blk_word;
    logic [3:0]  r_blk_idx;
    logic        r_blk_we;
    logic        r_pend_end;
    logic        r_pad_cont;
    logic        r_first;
    logic        r_len_done;
    logic        r_msg_done;

    logic        w_rx_ready;
    logic        w_pop;
    logic        w_is_cr;
    logic        w_byte_wr;
    logic        w_end_evt;
    logic        w_pad_wr;
    logic [7:0]  w_pad_byte;
    logic        w_wr;
    logic [7:0]  w_wr_byte;
    logic [31:0] w_acc_nxt;
    logic        w_word_full;
    logic        w_wait_done;

    // Once an end is pending no further message bytes may be taken.
    assign w_rx_ready  = !sys_rst && ((r_state == S_IDLE) ||
                         (r_state == S_FILL && r_pos != 7'd64 && !r_pend_end));
    assign w_pop       = rx_valid && w_rx_ready;
    assign w_is_cr     = (END_ON_CR != 0) && (rx_data == 8'h0D);
    assign w_byte_wr   = w_pop && !w_is_cr;
    assign w_end_evt   = msg_end || (w_pop && w_is_cr);
    assign w_wr        = w_byte_wr || w_pad_wr;
    assign w_wr_byte   = w_pad_wr ? w_pad_byte : rx_data;
    assign w_word_full = w_wr && (r_pos[1:0] == 2'd3);
    assign w_wait_done = (r_state == S_WAIT) && sha_done;

    always_comb begin
        w_acc_nxt = r_acc;
        case (r_pos[1:0])
            2'd0: w_acc_nxt[31:24] = w_wr_byte;
            2'd1: w_acc_nxt[23:16] = w_wr_byte;
            2'd2: w_acc_nxt[15:8]  = w_wr_byte;
            2'd3: w_acc_nxt[7:0]   = w_wr_byte;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pad_wr    = 1'b0;
        w_pad_byte  = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_byte_wr)      w_state_nxt = S_FILL;
                else if (w_end_evt) w_state_nxt = S_PAD80;
            end
            S_FILL: begin
                if (r_pos == 7'd64)  w_state_nxt = S_START;
                else if (r_pend_end) w_state_nxt = S_PAD80;
            end
            S_PAD80: begin
                w_pad_wr    = 1'b1;
                w_pad_byte  = 8'h80;
                w_state_nxt = S_PADZ;
            end
            S_PADZ: begin
                if (r_pos == 7'd56)      w_state_nxt = S_LENHI;
                else if (r_pos == 7'd64) w_state_nxt = S_START;
                else                     w_pad_wr    = 1'b1;
            end
            S_LENHI: w_state_nxt = S_LENLO;
            S_LENLO: w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (sha_done) begin
                    if (r_len_done)      w_state_nxt = S_IDLE;
                    else if (r_pad_cont) w_state_nxt = S_PADZ;
                    else if (r_pend_end) w_state_nxt = S_PAD80;
                    else                 w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_pos      <= 7'd0;
            r_byte_cnt <= 32'd0;
            r_pend_end <= 1'b0;
            r_pad_cont <= 1'b0;
            r_first    <= 1'b1;
            r_len_done <= 1'b0;
            r_msg_done <= 1'b0;
            r_blk_we   <= 1'b0;
            r_blk_word <= 32'd0;
            r_blk_idx  <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_msg_done <= w_wait_done && r_len_done;
            r_blk_we   <= w_word_full;
            if (w_wr)
                r_pos <= r_pos + 7'd1;
            if (w_word_full) begin
                r_blk_word <= w_acc_nxt;
                r_blk_idx  <= r_pos[5:2];
            end
            if (w_byte_wr)
                r_byte_cnt <= r_byte_cnt + 32'd1;
            if (w_end_evt)
                r_pend_end <= 1'b1;
            if (r_state == S_PADZ && r_pos == 7'd64)
                r_pad_cont <= 1'b1;
            if (r_state == S_LENLO)
                r_len_done <= 1'b1;
            if (r_state == S_START)
                r_first <= 1'b0;
            // A new block always starts at byte 0; the final block also closes the message.
            if (w_wait_done) begin
                r_pos      <= 7'd0;
                r_pad_cont <= 1'b0;
                if (r_len_done) begin
                    r_byte_cnt <= 32'd0;
                    r_pend_end <= 1'b0;
                    r_len_done <= 1'b0;
                    r_first    <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr)
            r_acc <= w_acc_nxt;
    end

    assign rx_ready  = w_rx_ready;
    assign busy      = !sys_rst && (r_state != S_IDLE);
    assign sha_start = !sys_rst && (r_state == S_START);
    assign sha_first = sha_start && r_first;
    assign msg_done  = !sys_rst && r_msg_done;
    assign blk_we    = !sys_rst && (r_blk_we || r_state == S_LENHI || r_state == S_LENLO);

    always_comb begin
        blk_word = r_blk_word;
        blk_idx  = r_blk_idx;
        if (sys_rst) begin
            blk_word = 32'd0;
            blk_idx  = 4'd0;
        end else if (r_state == S_LENHI) begin
            blk_word = {29'd0, r_byte_cnt[31:29]};
            blk_idx  = 4'd14;
        end else if (r_state == S_LENLO) begin
            blk_word = {r_byte_cnt[28:0], 3'b000};
            blk_idx  = 4'd15;
        end
    end

endmodule

// File: tb/tb_sha_pad_ctrl.sv
// Bench for sha_pad_ctrl: feeds messages (directed and random), emulates the SHA core
// handshake and compares captured blocks with a byte-level padding model.
module tb_sha_pad_ctrl;

    typedef logic [7:0]  byte_q[$];
    typedef logic [31:0] word_q[$];
    typedef int          int_q[$];

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        msg_end;
    logic [31:0] blk_word;
    logic [3:0]  blk_idx;
    logic        blk_we;
    logic        sha_start;
    logic        sha_first;
    logic        sha_done;
    logic        busy;
    logic        msg_done;

    always #5 clk = ~clk;

    sha_pad_ctrl #(.END_ON_CR(1)) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .msg_end(msg_end), .blk_word(blk_word), .blk_idx(blk_idx),
        .blk_we(blk_we), .sha_start(sha_start), .sha_first(sha_first),
        .sha_done(sha_done), .busy(busy), .msg_done(msg_done)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Monitor state: everything the DUT emits, appended in order.
    logic [31:0] blk_mem [16];
    logic [15:0] blk_mask = '0;
    word_q       got_words;
    int_q        got_first;
    int_q        got_mask;
    int_q        pop_cyc;
    int_q        we15_cyc;
    int_q        start_cyc;
    int          mon_cyc   = 0;
    int          done_cnt  = 0;
    int          wait_pops = 0;
    bit          waiting   = 0;

    always @(negedge clk) begin
        mon_cyc++;
        if (sys_rst) begin
            blk_mask = '0;
            waiting  = 0;
        end
        if (rx_valid && rx_ready) begin
            pop_cyc.push_back(mon_cyc);
            if (waiting) wait_pops++;
        end
        if (blk_we) begin
            blk_mem[blk_idx]  = blk_word;
            blk_mask[blk_idx] = 1'b1;
            if (blk_idx == 4'd15) we15_cyc.push_back(mon_cyc);
        end
        if (sha_start) begin
            for (int i = 0; i < 16; i++) got_words.push_back(blk_mem[i]);
            got_first.push_back(int'(sha_first));
            got_mask.push_back(int'(blk_mask));
            start_cyc.push_back(mon_cyc);
            blk_mask = '0;
            waiting  = 1;
        end
        if (sha_done) waiting = 0;
        if (msg_done) done_cnt++;
    end

    // Driver state
    byte_q tx;
    int    idx      = 0;
    bit    popped   = 0;
    bit    end_sent = 1;
    int    mode     = 0;
    int    core_cnt = 0;
    bit    core_en  = 1;
    int    last_base  = 0;
    int    last_pop   = 0;
    int    last_start = 0;
    int    last_we15  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference padding: message ++ 0x80 ++ zeros to 56 mod 64 ++ 64-bit bit length.
    function automatic void build_exp(input byte_q m, output word_q w);
        byte_q       p;
        logic [63:0] bits;
        p    = m;
        bits = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        w = {};
        for (int i = 0; i < p.size(); i += 4) w.push_back({p[i], p[i+1], p[i+2], p[i+3]});
    endfunction

    function automatic byte_q rand_msg(input int n);
        byte_q       q;
        logic [7:0]  b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(255, 0));
            if (b == 8'h0D) b = 8'h0E;
            q.push_back(b);
        end
        return q;
    endfunction

    function automatic logic [31:0] gw(input int i);
        if (last_base + i < got_words.size()) return got_words[last_base + i];
        return 32'hxxxxxxxx;
    endfunction

    function automatic int qget(input int_q q, input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1000;
    endfunction

    // One clock: advance the byte feed, emulate the core, drive next-cycle inputs.
    task automatic step();
        @(posedge clk); #1;
        if (popped) idx++;
        sha_done = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) sha_done = 1'b1;
        end
        if (sha_start && core_en) core_cnt = $urandom_range(4, 1);
        msg_end  = 1'b0;
        rx_valid = 1'b0;
        if (idx < tx.size()) begin
            rx_data  = tx[idx];
            rx_valid = ($urandom_range(3, 0) != 0);
        end else begin
            rx_data = 8'($urandom_range(255, 0));
        end
        if (!end_sent) begin
            if ((mode == 0 && idx == tx.size()) ||
                (mode == 1 && idx == tx.size() && sha_start) ||
                (mode == 3 && rx_valid && rx_ready && idx == tx.size() - 1)) begin
                msg_end  = 1'b1;
                end_sent = 1'b1;
            end
        end
        popped = rx_valid && rx_ready;
    endtask

    // md: 0 = msg_end after last byte, 1 = msg_end with sha_start, 2 = CR terminator, 3 = msg_end with last byte
    task automatic run_msg(input string tag, input byte_q m, input int md);
        word_q exp;
        int    b0, p0, d0, w0, t0, nb;
        build_exp(m, exp);
        tx = m;
        if (md == 2) tx.push_back(8'h0D);
        mode = md; idx = 0; end_sent = (md == 2); popped = 0;
        b0 = got_first.size(); p0 = pop_cyc.size(); d0 = done_cnt; w0 = wait_pops;
        last_base = b0 * 16; last_pop = p0; last_start = start_cyc.size(); last_we15 = we15_cyc.size();
        t0 = 0;
        while (done_cnt == d0 && t0 < 4000) begin
            step();
            t0++;
        end
        repeat (3) step();
        nb = got_first.size() - b0;
        chk({tag, " msg_done"}, done_cnt - d0, 1);
        chk({tag, " blocks"}, nb, exp.size() / 16);
        chk({tag, " pops"}, pop_cyc.size() - p0, tx.size());
        chk({tag, " wait_pops"}, wait_pops - w0, 0);
        for (int b = 0; b < nb && b < exp.size() / 16; b++) begin
            chk($sformatf("%s blk%0d first", tag, b), got_first[b0+b], (b == 0));
            chk($sformatf("%s blk%0d mask", tag, b), got_mask[b0+b], 32'h0000FFFF);
            for (int i = 0; i < 16; i++)
                chk($sformatf("%s blk%0d w%0d", tag, b, i), got_words[(b0+b)*16+i], exp[b*16+i]);
        end
    endtask

    initial begin
        byte_q m;
        int    b0, d0, k, n, md;
        sys_rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; msg_end = 1'b0; sha_done = 1'b0;
        tx = {};
        step();
        step();
        chk("rst rx_ready", rx_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst blk_we", blk_we, 0);
        chk("rst blk_word", blk_word, 0);
        chk("rst blk_idx", blk_idx, 0);
        chk("rst sha_start", sha_start, 0);
        chk("rst sha_first", sha_first, 0);
        chk("rst msg_done", msg_done, 0);
        sys_rst = 1'b0; #1;
        chk("idle rx_ready", rx_ready, 1);
        chk("idle busy", busy, 0);

        m = {};
        run_msg("empty", m, 0);
        chk("empty w0", gw(0), 32'h80000000);
        chk("empty w15", gw(15), 32'h00000000);

        m = {8'h61, 8'h62, 8'h63};
        run_msg("abc", m, 0);
        chk("abc w0", gw(0), 32'h61626380);
        chk("abc w14", gw(14), 32'h00000000);
        chk("abc w15", gw(15), 32'h00000018);

        m = {};
        for (int i = 0; i < 56; i++) m.push_back(8'h61);
        run_msg("a56", m, 0);
        chk("a56 w14", gw(14), 32'h80000000);
        chk("a56 w15", gw(15), 32'h00000000);
        chk("a56 b2w0", gw(16), 32'h00000000);
        chk("a56 b2w15", gw(31), 32'h000001C0);

        m = rand_msg(64);
        run_msg("b64", m, 1);
        chk("b64 b2w0", gw(16), 32'h80000000);
        chk("b64 b2w15", gw(31), 32'h00000200);
        chk("b64 we15 latency", qget(we15_cyc, last_we15) - qget(pop_cyc, last_pop + 63), 1);
        chk("b64 start latency", qget(start_cyc, last_start) - qget(pop_cyc, last_pop + 63), 2);

        m = {8'h61};
        run_msg("cr", m, 2);
        chk("cr w0", gw(0), 32'h61800000);
        chk("cr w15", gw(15), 32'h00000008);

        run_msg("len55", rand_msg(55), 3);
        run_msg("len63", rand_msg(63), 3);

        // Abort while the core is busy; its late completion must be ignored.
        core_en = 0;
        tx = rand_msg(20); mode = 0; idx = 0; end_sent = 0; popped = 0;
        b0 = got_first.size(); d0 = done_cnt;
        k = 0;
        while (got_first.size() == b0 && k < 500) begin
            step();
            k++;
        end
        chk("abort start seen", got_first.size() - b0, 1);
        step();
        sys_rst = 1'b1; #1;
        chk("abort rx_ready", rx_ready, 0);
        chk("abort busy", busy, 0);
        chk("abort blk_we", blk_we, 0);
        chk("abort blk_word", blk_word, 0);
        chk("abort sha_start", sha_start, 0);
        chk("abort msg_done", msg_done, 0);
        tx = {}; idx = 0; end_sent = 1; popped = 0;
        step();
        sys_rst = 1'b0; #1;
        chk("abort idle rx_ready", rx_ready, 1);
        chk("abort idle busy", busy, 0);
        chk("abort idle blk_word", blk_word, 0);
        chk("abort idle blk_idx", blk_idx, 0);
        sha_done = 1'b1;
        repeat (6) step();
        chk("abort no msg_done", done_cnt - d0, 0);
        chk("abort still idle", busy, 0);
        core_en = 1;
        run_msg("post-rst", rand_msg(10), 0);

        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(140, 0);
            md = $urandom_range(2, 0);
            if (md == 1) md = 3;
            if (md == 3 && n == 0) md = 0;
            run_msg($sformatf("rand%0d", r), rand_msg(n), md);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
